// File: rtl/udl_mod_counter_if.sv
// Control/status bundle for udl_mod_counter: count controls in, count and flags out.
interface udl_mod_counter_if #(
   parameter int N      = 8,
   parameter int STEP_W = 4
);
   logic              enable;
   logic              up;
   logic              load;
   logic              sync_clr;
   logic              sat;
   logic [STEP_W-1:0] step;
   logic [N-1:0]      max_val;
   logic [N-1:0]      L;
   logic              clr_flags;
   logic [N-1:0]      Q;
   logic              tc;
   logic              ovf;
   logic              unf;
   logic              at_max;
   logic              at_zero;

   modport master (
      output enable, up, load, sync_clr, sat, step, max_val, L, clr_flags,
      input  Q, tc, ovf, unf, at_max, at_zero
   );

   modport slave (
      input  enable, up, load, sync_clr, sat, step, max_val, L, clr_flags,
      output Q, tc, ovf, unf, at_max, at_zero
   );
endinterface

// File: rtl/udl_mod_counter.sv
// Up/down/load counter with programmable modulus, selectable step, wrap or
// saturate on bound crossing, terminal-count pulse and sticky ovf/unf flags.
module udl_mod_counter #(
   parameter int N      = 8,
   parameter int STEP_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   udl_mod_counter_if.slave   bus
);

   logic [N-1:0] r_q;
   logic         r_tc;
   logic         r_ovf;
   logic         r_unf;

   logic [N:0]   w_q_ext;
   logic [N:0]   w_step_ext;
   logic [N:0]   w_max_ext;
   logic [N:0]   w_max_p1;
   logic [N:0]   w_sum;
   logic [N:0]   w_up_wrap;
   logic [N:0]   w_dn_wrap;
   logic [N-1:0] w_q_nxt;
   logic         w_tc_nxt;
   logic         w_set_ovf;
   logic         w_set_unf;

   // All arithmetic carried in N+1 bits; a negative down-wrap lands above max_val.
   assign w_q_ext    = {1'b0, r_q};
   assign w_step_ext = {{(N+1-STEP_W){1'b0}}, bus.step};
   assign w_max_ext  = {1'b0, bus.max_val};
   assign w_max_p1   = w_max_ext + (N+1)'(1);
   assign w_sum      = w_q_ext + w_step_ext;
   assign w_up_wrap  = w_sum - w_max_p1;
   assign w_dn_wrap  = w_q_ext + w_max_p1 - w_step_ext;

   always_comb begin
      w_q_nxt   = r_q;
      w_tc_nxt  = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      if (bus.sync_clr) begin
         w_q_nxt = '0;
      end else if (bus.load) begin
         w_q_nxt = (bus.L > bus.max_val) ? bus.max_val : bus.L;
      end else if (bus.enable) begin
         if (r_q > bus.max_val) begin
            w_q_nxt = bus.sat ? bus.max_val : '0;
         end else if (bus.step != '0) begin
            if (bus.up) begin
               if (w_sum <= w_max_ext) begin
                  w_q_nxt = w_sum[N-1:0];
               end else begin
                  w_tc_nxt  = 1'b1;
                  w_set_ovf = 1'b1;
                  if (bus.sat)
                     w_q_nxt = bus.max_val;
                  else
                     w_q_nxt = (w_up_wrap <= w_max_ext) ? w_up_wrap[N-1:0] : '0;
               end
            end else begin
               if (w_q_ext >= w_step_ext) begin
                  w_q_nxt = r_q - w_step_ext[N-1:0];
               end else begin
                  w_tc_nxt  = 1'b1;
                  w_set_unf = 1'b1;
                  if (bus.sat)
                     w_q_nxt = '0;
                  else
                     w_q_nxt = (w_dn_wrap <= w_max_ext) ? w_dn_wrap[N-1:0] : '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q   <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_q   <= w_q_nxt;
         r_tc  <= w_tc_nxt;
         // A new set outranks a simultaneous clear.
         r_ovf <= w_set_ovf | (r_ovf & ~bus.clr_flags);
         r_unf <= w_set_unf | (r_unf & ~bus.clr_flags);
      end
   end

   assign bus.Q       = r_q;
   assign bus.tc      = r_tc;
   assign bus.ovf     = r_ovf;
   assign bus.unf     = r_unf;
   assign bus.at_max  = (r_q == bus.max_val);
   assign bus.at_zero = (r_q == '0);

endmodule

// File: tb/tb_udl_mod_counter.sv
// Directed scenarios plus randomized traffic checked against an integer
// reference model of the counter rules.
module tb_udl_mod_counter;

   localparam int N      = 8;
   localparam int STEP_W = 4;

   logic clk;
   logic reset_n;

   udl_mod_counter_if #(.N(N), .STEP_W(STEP_W)) bus ();

   udl_mod_counter #(.N(N), .STEP_W(STEP_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   int m_q, m_tc, m_ovf, m_unf;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input int en, input int up, input int ld, input int clr,
                        input int sat, input int step, input int mx, input int l,
                        input int cf);
      bus.enable    = en[0];
      bus.up        = up[0];
      bus.load      = ld[0];
      bus.sync_clr  = clr[0];
      bus.sat       = sat[0];
      bus.step      = STEP_W'(step);
      bus.max_val   = N'(mx);
      bus.L         = N'(l);
      bus.clr_flags = cf[0];
   endtask

   // Counter rules written directly as integer arithmetic.
   task automatic model_edge();
      int mx, st, s, r, set_o, set_u;
      mx = int'(bus.max_val);
      st = int'(bus.step);
      set_o = 0;
      set_u = 0;
      m_tc  = 0;
      if (bus.sync_clr) m_q = 0;
      else if (bus.load) m_q = (int'(bus.L) > mx) ? mx : int'(bus.L);
      else if (bus.enable) begin
         if (m_q > mx) m_q = bus.sat ? mx : 0;
         else if (st != 0) begin
            if (bus.up) begin
               s = m_q + st;
               if (s <= mx) m_q = s;
               else begin
                  set_o = 1; m_tc = 1;
                  r = s - (mx + 1);
                  m_q = bus.sat ? mx : ((r <= mx) ? r : 0);
               end
            end else begin
               if (m_q >= st) m_q = m_q - st;
               else begin
                  set_u = 1; m_tc = 1;
                  r = m_q + mx + 1 - st;
                  m_q = bus.sat ? 0 : ((r >= 0 && r <= mx) ? r : 0);
               end
            end
         end
      end
      m_ovf = (set_o != 0 || (m_ovf != 0 && !bus.clr_flags)) ? 1 : 0;
      m_unf = (set_u != 0 || (m_unf != 0 && !bus.clr_flags)) ? 1 : 0;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".Q"},       int'(bus.Q),       m_q);
      check({tag, ".tc"},      int'(bus.tc),      m_tc);
      check({tag, ".ovf"},     int'(bus.ovf),     m_ovf);
      check({tag, ".unf"},     int'(bus.unf),     m_unf);
      check({tag, ".at_max"},  int'(bus.at_max),  (m_q == int'(bus.max_val)) ? 1 : 0);
      check({tag, ".at_zero"}, int'(bus.at_zero), (m_q == 0) ? 1 : 0);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   initial begin
      int mx, tc_cnt;
      m_q = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
      reset_n = 1'b0;
      drive(0, 1, 0, 0, 0, 1, 9, 0, 0);
      repeat (3) @(negedge clk);
      compare_all("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: mod-10 count by 1, wrap
      tc_cnt = 0;
      drive(1, 1, 0, 0, 0, 1, 9, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         tick("t1");
         check("t1.Qconst", int'(bus.Q), i % 10);
         tc_cnt += int'(bus.tc);
      end
      check("t1.tc_pulses", tc_cnt, 1);
      check("t1.ovf", int'(bus.ovf), 1);

      // 2: step 3 from 8, wrap then saturate
      drive(0, 1, 1, 0, 0, 3, 9, 8, 1); tick("t2.ld");
      drive(1, 1, 0, 0, 0, 3, 9, 0, 0); tick("t2.wrap");
      check("t2.wrapQ", int'(bus.Q), 1);
      check("t2.wrapTc", int'(bus.tc), 1);
      drive(0, 1, 1, 0, 1, 3, 9, 8, 0); tick("t2.ld2");
      drive(1, 1, 0, 0, 1, 3, 9, 0, 0); tick("t2.sat");
      check("t2.satQ", int'(bus.Q), 9);
      check("t2.satTc", int'(bus.tc), 1);
      tick("t2.hold");
      check("t2.stayQ", int'(bus.Q), 9);

      // 3: down by 4 from 2 wrap; clr_flags with simultaneous underflow
      drive(0, 0, 1, 0, 0, 4, 9, 2, 1); tick("t3.ld");
      drive(1, 0, 0, 0, 0, 4, 9, 0, 0); tick("t3.unf");
      check("t3.Q", int'(bus.Q), 8);
      check("t3.unfflag", int'(bus.unf), 1);
      drive(0, 0, 1, 0, 0, 4, 9, 1, 0); tick("t3.ld2");
      drive(1, 0, 0, 0, 0, 4, 9, 0, 1); tick("t3.clrset");
      check("t3.unfsticky", int'(bus.unf), 1);
      drive(0, 0, 0, 0, 0, 4, 9, 0, 1); tick("t3.clr");
      check("t3.unfclr", int'(bus.unf), 0);

      // 4: clamped load, clear beats load
      drive(0, 1, 1, 0, 0, 1, 100, 200, 0); tick("t4.ld");
      check("t4.Q", int'(bus.Q), 100);
      drive(0, 1, 1, 1, 0, 1, 100, 50, 0); tick("t4.clr");
      check("t4.clrQ", int'(bus.Q), 0);

      // 5: max lowered below Q
      drive(0, 1, 1, 0, 0, 1, 100, 50, 0); tick("t5.ld");
      mx = m_ovf;
      drive(1, 1, 0, 0, 0, 1, 20, 0, 0); tick("t5.oor");
      check("t5.Q", int'(bus.Q), 0);
      check("t5.tc", int'(bus.tc), 0);
      check("t5.ovf", int'(bus.ovf), mx);

      // 6: async reset between edges
      drive(1, 1, 0, 0, 0, 7, 9, 0, 0);
      repeat (3) tick("t6.pre");
      #3 reset_n = 1'b0;
      #1;
      m_q = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
      compare_all("t6.rst");
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 1, 0, 0, 0, 1, 9, 0, 0);
      tick("t6.resume");
      check("t6.Q", int'(bus.Q), 1);

      // Randomized traffic
      mx = 12;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0)
            mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
         drive(($urandom_range(0, 9) < 8) ? 1 : 0,
               int'($urandom_range(0, 1)),
               ($urandom_range(0, 19) == 0) ? 1 : 0,
               ($urandom_range(0, 29) == 0) ? 1 : 0,
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)),
               mx,
               int'($urandom_range(0, 255)),
               ($urandom_range(0, 9) == 0) ? 1 : 0);
         tick("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
